// File: rtl/mult_pkg.sv
// Shared types, Booth triplet codes and helpers for the sequential radix-4 Booth multiplier.
package mult_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_t;

  // Radix-4 Booth triplets {b[2i+1], b[2i], b[2i-1]} and the digit each selects
  localparam logic [2:0] TRIP_Z0  = 3'b000;  //  0
  localparam logic [2:0] TRIP_P1A = 3'b001;  // +1
  localparam logic [2:0] TRIP_P1B = 3'b010;  // +1
  localparam logic [2:0] TRIP_P2  = 3'b011;  // +2
  localparam logic [2:0] TRIP_M2  = 3'b100;  // -2
  localparam logic [2:0] TRIP_M1A = 3'b101;  // -1
  localparam logic [2:0] TRIP_M1B = 3'b110;  // -1
  localparam logic [2:0] TRIP_Z1  = 3'b111;  //  0

  // Number of bits needed to hold values 0..v-1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth digit encoder: multiplier triplet to negate/zero/double select flags.
module booth_r4_enc
  import mult_pkg::*;
(
  input  logic [2:0] i_trip,
  output logic       o_neg,
  output logic       o_zero,
  output logic       o_two
);

  always_comb begin
    o_neg  = 1'b0;
    o_zero = 1'b0;
    o_two  = 1'b0;
    case (i_trip)
      TRIP_Z0, TRIP_Z1:   o_zero = 1'b1;
      TRIP_P1A, TRIP_P1B: o_zero = 1'b0;
      TRIP_P2:            o_two  = 1'b1;
      TRIP_M2: begin
        o_neg = 1'b1;
        o_two = 1'b1;
      end
      TRIP_M1A, TRIP_M1B: o_neg  = 1'b1;
      default:            o_zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle, signed or unsigned
// operands selected at start, start/done handshake with a busy flag.
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   out,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned N  = XW / 2;
  localparam int unsigned CW = clog2(N + 1);
  localparam int unsigned AW = 2 * XW;
  localparam int unsigned PW = XW + 2;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_last;

  logic [XW-1:0]   r_mcand;
  logic [XW-1:0]   r_mplier;
  logic            r_prev;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_acc;

  logic [XW-1:0]   w_a_ext;
  logic [XW-1:0]   w_b_ext;
  logic            w_neg;
  logic            w_zero;
  logic            w_two;
  logic [PW-1:0]   w_mag;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_hi;
  logic [PW-1:0]   w_sum;
  logic [AW-1:0]   w_acc_nxt;
  logic            w_unused_bits;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CW'(N - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Two extra bits let unsigned operands stay positive in a signed datapath
  assign w_a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign w_b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  booth_r4_enc u_enc (
    .i_trip ({r_mplier[1:0], r_prev}),
    .o_neg  (w_neg),
    .o_zero (w_zero),
    .o_two  (w_two)
  );

  // Partial product is added into the top half, then the whole accumulator shifts right by 2
  assign w_mag     = w_two ? {r_mcand[XW-1], r_mcand, 1'b0} : {{2{r_mcand[XW-1]}}, r_mcand};
  assign w_pp      = w_zero ? '0 : (w_neg ? (~w_mag) + PW'(1) : w_mag);
  assign w_hi      = {{2{r_acc[AW-1]}}, r_acc[AW-1:XW]};
  assign w_sum     = w_hi + w_pp;
  assign w_acc_nxt = {w_sum, r_acc[XW-1:2]};

  assign w_unused_bits = ^{r_acc[1:0], w_acc_nxt[AW-1:2*WIDTH]};

  // Operand, accumulator, counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prev   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      out      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_mcand  <= w_a_ext;
        r_mplier <= w_b_ext;
        r_prev   <= 1'b0;
        r_cnt    <= '0;
        r_acc    <= '0;
        busy     <= 1'b1;
      end else if (r_state == S_CALC) begin
        r_acc    <= w_acc_nxt;
        r_mplier <= {2'b00, r_mplier[XW-1:2]};
        r_prev   <= r_mplier[1];
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          out   <= w_acc_nxt[2*WIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          r_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq (WIDTH=16) against an integer-arithmetic reference.
module tb_mult_booth_seq;

  localparam int unsigned W   = 16;
  localparam int          LAT = 9;

  logic           clk;
  logic           reset;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] out;
  logic           done;
  logic           busy;

  int checks;
  int errors;

  mult_booth_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .out       (out),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint px;
    longint py;
    px = s ? longint'($signed(x)) : longint'({48'd0, x});
    py = s ? longint'($signed(y)) : longint'({48'd0, y});
    return 32'(px * py);
  endfunction

  // Issue one operation and wait (bounded) for done; reports latency and busy-high cycles
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                       output logic [2*W-1:0] res, output int lat, output int bcnt);
    @(negedge clk);
    a = ia; b = ib; is_signed = is; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (!done && busy) bcnt++;
    end
    res = out;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h done=%b busy=%b, expected 0/0/0", out, done, busy);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [2*W-1:0] res;
    int lat, bcnt;
    do_op(16'd3, 16'hFFFC, 1'b1, res, lat, bcnt);
    checks++;
    if (res !== 32'hFFFF_FFF4) begin
      errors++; $display("FAIL basic_result: got %h expected %h", res, 32'hFFFF_FFF4);
    end
    checks++;
    if (lat !== LAT) begin
      errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (bcnt !== LAT) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bcnt, LAT);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_one_cycle: got %b expected 0", done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out !== 32'hFFFF_FFF4) begin
      errors++; $display("FAIL out_hold: got %h expected %h", out, 32'hFFFF_FFF4);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ca [6] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h1234};
    logic [W-1:0]   cb [6] = '{16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic           cs [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2*W-1:0] ce [6] = '{32'h4000_0000, 32'hC000_8000, 32'hFFFE_0001,
                               32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
    logic [2*W-1:0] res;
    int lat, bcnt;
    for (int i = 0; i < 6; i++) begin
      do_op(ca[i], cb[i], cs[i], res, lat, bcnt);
      checks++;
      if (res !== ce[i] || lat !== LAT) begin
        errors++;
        $display("FAIL corner_%0d: got %h lat %0d expected %h lat %0d", i, res, lat, ce[i], LAT);
      end
    end
  endtask

  task automatic test_ignore_midcalc();
    logic [2*W-1:0] exp_r;
    int lat;
    exp_r = ref_mul(16'd1234, 16'hFDC9, 1'b1);
    @(negedge clk);
    a = 16'd1234; b = 16'hFDC9; is_signed = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom); start = (k % 2 == 0);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out !== exp_r || lat !== LAT) begin
      errors++;
      $display("FAIL ignore_midcalc: got %h lat %0d expected %h lat %0d", out, lat, exp_r, LAT);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL no_stray_accept: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] e1, e2, r1;
    int lat, gap;
    e1 = ref_mul(16'h00FF, 16'h0101, 1'b0);
    e2 = ref_mul(16'hC350, 16'h7FFF, 1'b1);
    @(negedge clk);
    a = 16'h00FF; b = 16'h0101; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    r1 = out;
    a = 16'hC350; b = 16'h7FFF; is_signed = 1'b1;
    checks++;
    if (r1 !== e1 || lat !== LAT) begin
      errors++; $display("FAIL b2b_first: got %h lat %0d expected %h lat %0d", r1, lat, e1, LAT);
    end
    @(posedge clk); #1;
    start = 1'b0;
    gap = 1;
    while (!done && gap < 30) begin
      @(posedge clk); #1;
      gap++;
    end
    checks++;
    if (gap !== LAT + 1) begin
      errors++; $display("FAIL b2b_spacing: got %0d expected %0d", gap, LAT + 1);
    end
    checks++;
    if (out !== e2) begin
      errors++; $display("FAIL b2b_second: got %h expected %h", out, e2);
    end
  endtask

  task automatic test_reset_midcalc();
    logic [2*W-1:0] res;
    int lat, bcnt, seen;
    @(negedge clk);
    a = 16'h1357; b = 16'h2468; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (out !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_midcalc: out=%h done=%b busy=%b expected 0/0/0", out, done, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", seen);
    end
    do_op(16'hABCD, 16'h8001, 1'b1, res, lat, bcnt);
    checks++;
    if (res !== ref_mul(16'hABCD, 16'h8001, 1'b1) || lat !== LAT) begin
      errors++;
      $display("FAIL after_reset_op: got %h lat %0d expected %h lat %0d",
               res, lat, ref_mul(16'hABCD, 16'h8001, 1'b1), LAT);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pick [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [W-1:0] ra, rb;
    logic rs;
    logic [2*W-1:0] res, exp_r;
    int lat, bcnt;
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : W'($urandom);
      rs = 1'($urandom);
      exp_r = ref_mul(ra, rb, rs);
      do_op(ra, rb, rs, res, lat, bcnt);
      checks++;
      if (res !== exp_r || lat !== LAT) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h s=%b got %h lat %0d expected %h lat %0d",
                 i, ra, rb, rs, res, lat, exp_r, LAT);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_corners();
    test_ignore_midcalc();
    test_back_to_back();
    test_reset_midcalc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
